regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register file generalising the CPU's fixed 32 x 64-bit, 32:1 combinational read select: configurable data width, depth and read-port count. Reads are registered, with a per-port valid strobe. The block adds a hardwired zero register, same-cycle write-to-read bypass, and a multi-cycle bulk-clear sweep. It sits in the decode stage of the pipelined LEGv8 datapath and replaces the flat register array plus its read muxes.

## Interface
Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 32, number of registers; must be a power of two, at least 2.
- NUM_RD, 2, number of independent read ports (1..4).
- ZERO_REG, DEPTH-1, index that always reads 0 and ignores writes (X31/XZR).
- BYPASS, 1, 1 = write-first on same-cycle address match; 0 = read-first.
- ADDR_W, $clog2(DEPTH), derived; never overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write index.
- wr_data  input  WIDTH  write data.
- wr_ack  output  1  combinational; high when wr_en && !busy, meaning the write is accepted this edge.
- rd_en  input  NUM_RD  per-port read request.
- rd_addr  input  NUM_RD x ADDR_W  per-port read index, packed [NUM_RD-1:0][ADDR_W-1:0].
- rd_data  output  NUM_RD x WIDTH  registered read data, packed [NUM_RD-1:0][WIDTH-1:0].
- rd_valid  output  NUM_RD  high for exactly one cycle after a sampled rd_en.
- clear  input  1  starts the bulk-clear sweep when idle.
- busy  output  1  registered; high while the sweep runs.

## Operation
- Storage: DEPTH x WIDTH flops. Entry ZERO_REG is never written and always reads 0.
- Write: on an edge where wr_en && !busy && wr_addr != ZERO_REG, mem[wr_addr] <= wr_data.
  - wr_ack is still high for a ZERO_REG write; the write is discarded silently.
  - While busy, wr_ack = 0 and the write is dropped. The requester must hold or retry.
- Read, per port p: on an edge with rd_en[p], rd_data[p] <= selected value and rd_valid[p] <= 1.
  - With rd_en[p] low: rd_valid[p] <= 0 and rd_data[p] holds its previous value.
- Read select: value = 0 if rd_addr[p] == ZERO_REG. Otherwise:
  - if BYPASS, there is an effective write this edge, and the write address matches: wr_data;
  - otherwise mem[rd_addr[p]].
- Read ports are fully independent. Any number of ports may read the same address in the same cycle.
- Clear FSM, two states:
  - IDLE -> SWEEP when clear && !reset. The sweep counter loads 0 and busy <= 1.
  - In SWEEP, each edge sets mem[cnt] <= 0 and cnt <= cnt+1.
  - After the edge that clears cnt == DEPTH-1, the FSM returns to IDLE and busy <= 0.
  - The sweep write is the effective write for bypass: a read of address cnt on that edge returns 0 when BYPASS=1.
  - clear asserted during SWEEP is ignored and does not restart the sweep.
- Reset, which also applies mid-sweep:
  - all mem entries <= 0;
  - rd_data <= 0 and rd_valid <= 0;
  - busy <= 0, FSM -> IDLE, cnt <= 0.
  - Reset overrides any write, read or clear sampled on the same edge.

## Timing
- Write latency: data is visible to a normal (non-bypass) read issued on the next edge.
- Read latency: 1 cycle. rd_en sampled at edge N puts data and valid on the outputs after edge N.
- Bypass adds no latency. With BYPASS=0, a same-edge read of the written address returns the old value.
- Sweep duration: busy is high for exactly DEPTH cycles, starting from the edge after clear is sampled in IDLE.
- wr_ack is combinational from wr_en and busy, with no path from the address or data inputs.
- Critical path is the DEPTH:1 read select plus the bypass compare. Width and depth are not otherwise constrained.

## Test plan
- Reset, then write 0xDEADBEEF_00000001 to reg 5 and read port 0 at addr 5 the next cycle -> rd_data[0] = 0xDEADBEEF_00000001 and rd_valid[0] = 1 for exactly one cycle.
- Write 0xFFFF_FFFF_FFFF_FFFF to reg 31 (ZERO_REG) with wr_ack = 1, then read 31 on both ports -> both return 0.
- Same-edge write of 0x1234 to reg 7 while port 1 reads 7 (old value 0xAAAA) -> BYPASS=1 returns 0x1234; BYPASS=0 returns 0xAAAA, and the next read returns 0x1234.
- Preload regs 0..30 with their index values, pulse clear -> busy is high for 32 cycles; a write during busy sees wr_ack = 0 and is dropped; afterwards every register reads 0.
- Assert reset at sweep cycle 10 -> the next cycle shows busy = 0, all rd_data = 0 and rd_valid = 0, and every register reads 0.
- Instance with WIDTH=16, DEPTH=8, NUM_RD=3, ZERO_REG=0: write reg i = 0x1000+i for i = 1..7, then read regs 0, 3 and 7 on ports 0..2 in one cycle -> 0x0000, 0x1003, 0x1007.

Source files
------------

// File: rtl/regfile_param_if.sv
// Register-file access bundle: one write port, NUM_RD registered read ports and the
// bulk-clear control.
//   master : requester side (drives write/read/clear requests, sees ack/data/valid/busy)
//   slave  : register file side
// Signals:
//   wr_en/wr_addr/wr_data : write request; wr_ack is high when the write is taken this edge
//   rd_en/rd_addr         : per-port read request, packed [NUM_RD-1:0][ADDR_W-1:0]
//   rd_data/rd_valid      : per-port registered read result, valid for one cycle
//   clear/busy            : start bulk clear; busy high while the sweep runs
interface regfile_param_if #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic                               wr_en;
  logic [ADDR_W-1:0]                  wr_addr;
  logic [WIDTH-1:0]                   wr_data;
  logic                               wr_ack;
  logic [NUM_RD-1:0]                  rd_en;
  logic [NUM_RD-1:0][ADDR_W-1:0]      rd_addr;
  logic [NUM_RD-1:0][WIDTH-1:0]       rd_data;
  logic [NUM_RD-1:0]                  rd_valid;
  logic                               clear;
  logic                               busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clear,
    input  wr_ack, rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clear,
    output wr_ack, rd_data, rd_valid, busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file for the decode stage: DEPTH x WIDTH storage, NUM_RD
// independent registered read ports, hardwired zero register, optional write-first
// bypass and a DEPTH-cycle bulk-clear sweep.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset (clears storage, read outputs and the sweep)
//   bus   : regfile_param_if.slave, interface parameters must match WIDTH/DEPTH/NUM_RD
module regfile_param #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = DEPTH - 1,
  parameter int unsigned BYPASS   = 1,
  localparam int unsigned ADDR_W  = $clog2(DEPTH)
) (
  input logic            clk,
  input logic            reset,
  regfile_param_if.slave bus
);

  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic {StIdle, StSweep} state_e;

  state_e                        state_q, state_d;
  logic [ADDR_W-1:0]             cnt_q, cnt_d;
  logic                          busy_q, busy_d;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_q, mem_d;
  logic [NUM_RD-1:0][WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]             rd_valid_q, rd_valid_d;

  // The single storage write happening on this edge: either a sweep clear or an
  // accepted external write. The read bypass looks at exactly this.
  logic                          eff_we;
  logic [ADDR_W-1:0]             eff_addr;
  logic [WIDTH-1:0]              eff_data;

  always_comb begin
    eff_we   = 1'b0;
    eff_addr = cnt_q;
    eff_data = '0;
    if (state_q == StSweep) begin
      eff_we = 1'b1;
    end else if (bus.wr_en && (bus.wr_addr != ZeroAddr)) begin
      eff_we   = 1'b1;
      eff_addr = bus.wr_addr;
      eff_data = bus.wr_data;
    end
  end

  // A zero-register write is still acknowledged, it just never lands.
  assign bus.wr_ack = bus.wr_en & ~busy_q;

  always_comb begin
    mem_d = mem_q;
    if (eff_we) begin
      mem_d[eff_addr] = eff_data;
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = bus.rd_en;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (bus.rd_en[p]) begin
        if (bus.rd_addr[p] == ZeroAddr) begin
          rd_data_d[p] = '0;
        end else if ((BYPASS != 0) && eff_we && (eff_addr == bus.rd_addr[p])) begin
          rd_data_d[p] = eff_data;
        end else begin
          rd_data_d[p] = mem_q[bus.rd_addr[p]];
        end
      end
    end
  end

  // Clear FSM: a clear seen while sweeping is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.clear) begin
          state_d = StSweep;
          cnt_d   = '0;
        end
      end
      StSweep: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d = (state_d == StSweep);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      mem_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three instances (default BYPASS=1, default BYPASS=0 sharing
// the same stimulus, and a 16-bit/8-deep/3-port instance with ZERO_REG=0). A reference
// model predicts each read result and queues it; a negedge monitor matches DUT output.
module tb_regfile_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus shared by dut_a and dut_b.
  logic            rst_ab, w_en, clr;
  logic [4:0]      w_addr;
  logic [63:0]     w_data;
  logic [1:0]      r_en;
  logic [1:0][4:0] r_addr;
  // Stimulus for dut_c.
  logic            rst_c, c_w_en, c_clr;
  logic [2:0]      c_w_addr;
  logic [15:0]     c_w_data;
  logic [2:0]      c_r_en;
  logic [2:0][2:0] c_r_addr;

  regfile_param_if bus_a ();
  regfile_param_if bus_b ();
  regfile_param_if #(.WIDTH(16), .DEPTH(8), .NUM_RD(3)) bus_c ();

  assign bus_a.wr_en = w_en;     assign bus_b.wr_en = w_en;
  assign bus_a.wr_addr = w_addr; assign bus_b.wr_addr = w_addr;
  assign bus_a.wr_data = w_data; assign bus_b.wr_data = w_data;
  assign bus_a.rd_en = r_en;     assign bus_b.rd_en = r_en;
  assign bus_a.rd_addr = r_addr; assign bus_b.rd_addr = r_addr;
  assign bus_a.clear = clr;      assign bus_b.clear = clr;
  assign bus_c.wr_en = c_w_en;
  assign bus_c.wr_addr = c_w_addr;
  assign bus_c.wr_data = c_w_data;
  assign bus_c.rd_en = c_r_en;
  assign bus_c.rd_addr = c_r_addr;
  assign bus_c.clear = c_clr;

  regfile_param dut_a (.clk(clk), .reset(rst_ab), .bus(bus_a));
  regfile_param #(.BYPASS(0)) dut_b (.clk(clk), .reset(rst_ab), .bus(bus_b));
  regfile_param #(.WIDTH(16), .DEPTH(8), .NUM_RD(3), .ZERO_REG(0)) dut_c (
    .clk(clk), .reset(rst_c), .bus(bus_c)
  );

  // Reference model state.
  logic [63:0] m_ab [32];
  bit          busy_ab;
  int          left_ab;   // sweep entries still to clear
  logic [15:0] m_c [8];
  bit          busy_c;
  int          left_c;

  typedef struct {
    int          port;
    logic [63:0] data;
  } exp_t;
  exp_t qa[$], qb[$], qc[$];

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: check combinational outputs against the model, predict the edge, advance.
  task automatic cycle();
    exp_t pa[$], pb[$], pc[$];
    bit   we;
    int   wa, ra, clr_idx;
    logic [63:0] wd, old;
    #1;
    if (!rst_ab) begin
      chk(bus_a.wr_ack == (w_en && !busy_ab), "a_wr_ack", 64'(bus_a.wr_ack), 64'(w_en && !busy_ab));
      chk(bus_b.wr_ack == (w_en && !busy_ab), "b_wr_ack", 64'(bus_b.wr_ack), 64'(w_en && !busy_ab));
      chk(bus_a.busy == busy_ab, "a_busy", 64'(bus_a.busy), 64'(busy_ab));
      chk(bus_b.busy == busy_ab, "b_busy", 64'(bus_b.busy), 64'(busy_ab));
    end
    if (!rst_c) begin
      chk(bus_c.wr_ack == (c_w_en && !busy_c), "c_wr_ack", 64'(bus_c.wr_ack), 64'(c_w_en && !busy_c));
      chk(bus_c.busy == busy_c, "c_busy", 64'(bus_c.busy), 64'(busy_c));
    end
    // 32 x 64, zero register 31
    if (rst_ab) begin
      foreach (m_ab[i]) m_ab[i] = '0;
      busy_ab = 0;
      left_ab = 0;
    end else begin
      we = 0; wa = 0; wd = '0;
      if (busy_ab) begin
        we = 1; wa = 32 - left_ab; wd = '0;
      end else if (w_en && w_addr != 5'd31) begin
        we = 1; wa = int'(w_addr); wd = w_data;
      end
      for (int p = 0; p < 2; p++) begin
        if (r_en[p]) begin
          ra  = int'(r_addr[p]);
          old = (ra == 31) ? 64'd0 : m_ab[ra];
          pb.push_back('{port: p, data: old});
          pa.push_back('{port: p, data: (ra != 31 && we && wa == ra) ? wd : old});
        end
      end
      if (we) m_ab[wa] = wd;
      if (busy_ab) begin
        left_ab--;
        if (left_ab == 0) busy_ab = 0;
      end else if (clr) begin
        busy_ab = 1;
        left_ab = 32;
      end
    end
    // 8 x 16, zero register 0, bypass on
    if (rst_c) begin
      foreach (m_c[i]) m_c[i] = '0;
      busy_c = 0;
      left_c = 0;
    end else begin
      clr_idx = busy_c ? 8 - left_c : -1;
      for (int p = 0; p < 3; p++) begin
        if (c_r_en[p]) begin
          ra = int'(c_r_addr[p]);
          if (ra == 0)                                       old = 64'd0;
          else if (clr_idx == ra)                            old = 64'd0;
          else if (!busy_c && c_w_en && int'(c_w_addr) == ra) old = 64'(c_w_data);
          else                                               old = 64'(m_c[ra]);
          pc.push_back('{port: p, data: old});
        end
      end
      if (busy_c) begin
        m_c[clr_idx] = '0;
        left_c--;
        if (left_c == 0) busy_c = 0;
      end else begin
        if (c_w_en && c_w_addr != 3'd0) m_c[c_w_addr] = c_w_data;
        if (c_clr) begin
          busy_c = 1;
          left_c = 8;
        end
      end
    end
    @(posedge clk);
    foreach (pa[i]) qa.push_back(pa[i]);
    foreach (pb[i]) qb.push_back(pb[i]);
    foreach (pc[i]) qc.push_back(pc[i]);
    #1;
  endtask

  // Monitor: every valid must match the oldest prediction, and every prediction made for
  // the last edge must have been consumed by now.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    for (int p = 0; p < 2; p++) begin
      if (bus_a.rd_valid[p] === 1'b1) begin
        ok = (qa.size() != 0) && (qa[0].port == p);
        chk(ok, "a_rd_valid_expected", 64'(p), 64'(p));
        if (ok) begin
          e = qa.pop_front();
          chk(bus_a.rd_data[p] == e.data, "a_rd_data", bus_a.rd_data[p], e.data);
        end
      end
      if (bus_b.rd_valid[p] === 1'b1) begin
        ok = (qb.size() != 0) && (qb[0].port == p);
        chk(ok, "b_rd_valid_expected", 64'(p), 64'(p));
        if (ok) begin
          e = qb.pop_front();
          chk(bus_b.rd_data[p] == e.data, "b_rd_data", bus_b.rd_data[p], e.data);
        end
      end
    end
    for (int p = 0; p < 3; p++) begin
      if (bus_c.rd_valid[p] === 1'b1) begin
        ok = (qc.size() != 0) && (qc[0].port == p);
        chk(ok, "c_rd_valid_expected", 64'(p), 64'(p));
        if (ok) begin
          e = qc.pop_front();
          chk(64'(bus_c.rd_data[p]) == e.data, "c_rd_data", 64'(bus_c.rd_data[p]), e.data);
        end
      end
    end
    chk(qa.size() == 0, "a_missing_rd_valid", 64'(qa.size()), 64'd0);
    chk(qb.size() == 0, "b_missing_rd_valid", 64'(qb.size()), 64'd0);
    chk(qc.size() == 0, "c_missing_rd_valid", 64'(qc.size()), 64'd0);
    qa.delete(); qb.delete(); qc.delete();
  end

  task automatic read_all_ab();
    for (int i = 0; i < 32; i++) begin
      r_en = 2'b11;
      r_addr[0] = 5'(i);
      r_addr[1] = 5'(31 - i);
      cycle();
    end
    r_en = '0;
  endtask

  task automatic preload_ab(input int base);
    for (int i = 0; i < 31; i++) begin
      w_en = 1'b1; w_addr = 5'(i); w_data = 64'(base + i);
      cycle();
    end
    w_en = 1'b0;
  endtask

  initial begin
    int n;
    rst_ab = 1; w_en = 0; clr = 0; w_addr = '0; w_data = '0; r_en = '0; r_addr = '0;
    rst_c = 1; c_w_en = 0; c_clr = 0; c_w_addr = '0; c_w_data = '0; c_r_en = '0;
    c_r_addr = '0;
    foreach (m_ab[i]) m_ab[i] = '0;
    foreach (m_c[i]) m_c[i] = '0;
    busy_ab = 0; left_ab = 0; busy_c = 0; left_c = 0;
    cycle(); cycle();
    rst_ab = 0; rst_c = 0;

    // Reset state
    chk(bus_a.rd_valid == 0 && bus_b.rd_valid == 0, "reset_rd_valid_ab",
        64'({bus_a.rd_valid, bus_b.rd_valid}), 64'd0);
    chk(bus_c.rd_valid == 0, "reset_rd_valid_c", 64'(bus_c.rd_valid), 64'd0);
    chk(bus_a.rd_data == '0 && bus_b.rd_data == '0 && bus_c.rd_data == '0,
        "reset_rd_data", bus_a.rd_data[0], 64'd0);

    // Write then read reg 5, valid for exactly one cycle
    w_en = 1; w_addr = 5'd5; w_data = 64'hDEADBEEF_00000001;
    cycle();
    w_en = 0; r_en = 2'b01; r_addr[0] = 5'd5;
    cycle();
    chk(bus_a.rd_valid == 2'b01, "read5_valid_pulse", 64'(bus_a.rd_valid), 64'd1);
    chk(bus_a.rd_data[0] == 64'hDEADBEEF_00000001, "read5_data", bus_a.rd_data[0],
        64'hDEADBEEF_00000001);
    r_en = '0;
    cycle();
    chk(bus_a.rd_valid == 2'b00, "read5_valid_drop", 64'(bus_a.rd_valid), 64'd0);
    chk(bus_a.rd_data[0] == 64'hDEADBEEF_00000001, "read5_data_hold", bus_a.rd_data[0],
        64'hDEADBEEF_00000001);

    // Zero register write is acked and discarded
    w_en = 1; w_addr = 5'd31; w_data = '1;
    cycle();
    w_en = 0; r_en = 2'b11; r_addr[0] = 5'd31; r_addr[1] = 5'd31;
    cycle();
    r_en = '0;

    // Same-edge write/read of reg 7
    w_en = 1; w_addr = 5'd7; w_data = 64'hAAAA;
    cycle();
    w_data = 64'h1234; r_en = 2'b10; r_addr[1] = 5'd7;
    cycle();
    chk(bus_a.rd_data[1] == 64'h1234, "bypass_on", bus_a.rd_data[1], 64'h1234);
    chk(bus_b.rd_data[1] == 64'hAAAA, "bypass_off", bus_b.rd_data[1], 64'hAAAA);
    w_en = 0;
    cycle();
    r_en = '0;

    // Bulk clear with a dropped write and reads racing the sweep
    preload_ab(0);
    clr = 1;
    cycle();
    clr = 0;
    n = 0;
    while (bus_a.busy === 1'b1 && n < 100) begin
      r_en = 2'b11; r_addr[0] = 5'(n); r_addr[1] = 5'(n + 1);
      w_en = (n == 10); w_addr = 5'd2; w_data = 64'h55;
      clr = (n == 12);
      cycle();
      n++;
    end
    w_en = 0; r_en = '0; clr = 0;
    chk(n == 32, "sweep_busy_cycles", 64'(n), 64'd32);
    read_all_ab();

    // Reset in the middle of a sweep
    preload_ab(100);
    clr = 1;
    cycle();
    clr = 0;
    for (int i = 0; i < 10; i++) begin
      r_en = 2'(i); r_addr[0] = 5'($urandom_range(0, 31)); r_addr[1] = 5'($urandom_range(0, 31));
      cycle();
    end
    rst_ab = 1; r_en = 2'b11; w_en = 1; w_addr = 5'd4; w_data = 64'h77; clr = 1;
    cycle();
    rst_ab = 0; r_en = '0; w_en = 0; clr = 0;
    chk(bus_a.busy == 0 && bus_b.busy == 0, "midsweep_reset_busy",
        64'({bus_a.busy, bus_b.busy}), 64'd0);
    chk(bus_a.rd_valid == 0 && bus_b.rd_valid == 0, "midsweep_reset_valid",
        64'({bus_a.rd_valid, bus_b.rd_valid}), 64'd0);
    chk(bus_a.rd_data == '0 && bus_b.rd_data == '0, "midsweep_reset_data",
        bus_a.rd_data[0] | bus_a.rd_data[1], 64'd0);
    read_all_ab();

    // Randomised traffic, reads biased towards the write address
    for (int i = 0; i < 400; i++) begin
      w_en   = 1'($urandom_range(0, 1));
      w_addr = 5'($urandom_range(0, 31));
      w_data = {$urandom, $urandom};
      r_en   = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++)
        r_addr[p] = ($urandom_range(0, 2) == 0) ? w_addr : 5'($urandom_range(0, 31));
      clr    = ($urandom_range(0, 59) == 0);
      rst_ab = ($urandom_range(0, 199) == 0);
      cycle();
    end
    w_en = 0; r_en = '0; clr = 0; rst_ab = 0;

    // Small instance: ZERO_REG = 0, three ports
    for (int i = 1; i < 8; i++) begin
      c_w_en = 1; c_w_addr = 3'(i); c_w_data = 16'(16'h1000 + i);
      cycle();
    end
    c_w_addr = 3'd0; c_w_data = 16'hFFFF;
    cycle();
    c_w_en = 0; c_r_en = 3'b111;
    c_r_addr[0] = 3'd0; c_r_addr[1] = 3'd3; c_r_addr[2] = 3'd7;
    cycle();
    chk(bus_c.rd_data == {16'h1007, 16'h1003, 16'h0000}, "c_three_port_read",
        64'(bus_c.rd_data), 64'h1007_1003_0000);
    c_r_en = '0;
    for (int i = 0; i < 250; i++) begin
      c_w_en   = 1'($urandom_range(0, 1));
      c_w_addr = 3'($urandom_range(0, 7));
      c_w_data = 16'($urandom);
      c_r_en   = 3'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++)
        c_r_addr[p] = ($urandom_range(0, 2) == 0) ? c_w_addr : 3'($urandom_range(0, 7));
      c_clr = ($urandom_range(0, 29) == 0);
      rst_c = ($urandom_range(0, 149) == 0);
      cycle();
    end
    c_w_en = 0; c_r_en = '0; c_clr = 0; rst_c = 0;
    cycle();
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
